// File: rtl/c3sram_row_sequencer.sv
// Command-level row sequencer for the C3SRAM write/read controller: splits a
// multi-row command into single-row controller requests, streaming row data in or out.
module c3sram_row_sequencer #(
  parameter int unsigned NumRows = 8,
  parameter int unsigned NumCols = 8,
  localparam int unsigned AddrW = $clog2(NumRows),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [AddrW-1:0]   base_addr_i,
  input  logic [CntW-1:0]    count_i,
  output logic               busy_o,
  output logic               cmd_done_o,
  input  logic               in_valid_i,
  input  logic [NumCols-1:0] in_data_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  output logic [NumCols-1:0] out_data_o,
  input  logic               out_ready_i,
  input  logic [NumCols-1:0] rd_data_i,
  output logic               ctrl_write_o,
  output logic               ctrl_read_o,
  output logic [AddrW-1:0]   ctrl_addr_o,
  output logic [NumCols-1:0] ctrl_wr_data_o,
  input  logic               ctrl_ready_i,
  input  logic               ctrl_done_i
);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StDrain, StFinish} state_e;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [AddrW-1:0]     row_q, row_d;
  logic [CntW-1:0]      rem_q, rem_d;
  logic [NumCols-1:0]   wr_data_q, wr_data_d;
  logic [NumCols-1:0]   out_data_q, out_data_d;
  logic                 busy_q, cmd_done_q, in_ready_q, out_valid_q, ctrl_write_q, ctrl_read_q;
  logic [CntW-1:0]      count_sat;
  logic [AddrW-1:0]     row_inc;

  always_comb begin
    count_sat  = (count_i > CntW'(NumRows)) ? CntW'(NumRows) : count_i;
    row_inc    = (row_q == AddrW'(NumRows - 1)) ? '0 : row_q + 1'b1;
    state_d    = state_q;
    mode_d     = mode_q;
    row_d      = row_q;
    rem_d      = rem_q;
    wr_data_d  = wr_data_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d = mode_i;
          row_d  = base_addr_i;
          rem_d  = count_sat;
          if (count_sat == '0) state_d = StFinish;
          else                 state_d = mode_i ? StIssue : StFetch;
        end
      end
      StFetch: begin
        if (in_valid_i) begin
          wr_data_d = in_data_i;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (ctrl_ready_i) state_d = StWait;
      end
      StWait: begin
        if (ctrl_done_i) begin
          rem_d = rem_q - 1'b1;
          row_d = row_inc;
          if (mode_q) begin
            out_data_d = rd_data_i;
            state_d    = StDrain;
          end else begin
            // rem_q still holds the pre-decrement count here
            state_d = (rem_q == CntW'(1)) ? StFinish : StFetch;
          end
        end
      end
      StDrain: begin
        if (out_ready_i) state_d = (rem_q == '0) ? StFinish : StIssue;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Handshake outputs are registered decodes of the next state, so they depend on state only.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= StIdle;
      mode_q       <= 1'b0;
      row_q        <= '0;
      rem_q        <= '0;
      wr_data_q    <= '0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      cmd_done_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      ctrl_write_q <= 1'b0;
      ctrl_read_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      row_q        <= row_d;
      rem_q        <= rem_d;
      wr_data_q    <= wr_data_d;
      out_data_q   <= out_data_d;
      busy_q       <= (state_d != StIdle);
      cmd_done_q   <= (state_d == StFinish);
      in_ready_q   <= (state_d == StFetch);
      out_valid_q  <= (state_d == StDrain);
      ctrl_write_q <= (state_d == StIssue) && !mode_d;
      ctrl_read_q  <= (state_d == StIssue) && mode_d;
    end
  end

  assign busy_o         = busy_q;
  assign cmd_done_o     = cmd_done_q;
  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign ctrl_write_o   = ctrl_write_q;
  assign ctrl_read_o    = ctrl_read_q;
  assign ctrl_addr_o    = row_q;
  assign ctrl_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_c3sram_row_sequencer.sv
// Scoreboard bench for c3sram_row_sequencer: directed commands against a small
// controller model; a negedge monitor pops expected requests and read beats.
module tb_c3sram_row_sequencer;
  localparam int unsigned NumRows = 8;
  localparam int unsigned NumCols = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 4;
  localparam int D = 4;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } req_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start_i = 1'b0, mode_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] count_i = '0;
  logic busy_o, cmd_done_o, in_ready_o, out_valid_o, ctrl_write_o, ctrl_read_o;
  logic in_valid_i = 1'b0, out_ready_i = 1'b1, ctrl_ready_i = 1'b1, ctrl_done_i = 1'b0;
  logic [7:0] in_data_i = '0, rd_data_i = '0, out_data_o, ctrl_wr_data_o;
  logic [AW-1:0] ctrl_addr_o;

  c3sram_row_sequencer #(.NumRows(NumRows), .NumCols(NumCols)) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .mode_i(mode_i), .base_addr_i(base_addr_i),
    .count_i(count_i), .busy_o(busy_o), .cmd_done_o(cmd_done_o), .in_valid_i(in_valid_i),
    .in_data_i(in_data_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .out_ready_i(out_ready_i), .rd_data_i(rd_data_i),
    .ctrl_write_o(ctrl_write_o), .ctrl_read_o(ctrl_read_o), .ctrl_addr_o(ctrl_addr_o),
    .ctrl_wr_data_o(ctrl_wr_data_o), .ctrl_ready_i(ctrl_ready_i), .ctrl_done_i(ctrl_done_i)
  );

  always #5 clk = ~clk;

  req_t exp_req_q[$];
  logic [7:0] exp_out_q[$], in_q[$], rd_q[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  int acc_cnt = 0, req_cyc_cnt = 0, done_cnt = 0, done_cyc = 0;
  int last_cdone_cyc = 0, last_out_cyc = 0, first_req_cyc = -1, start_cyc = 0;
  int cd = 0, stall_left = 0, out_hold = 0;
  logic acc_fire = 1'b0, in_fire = 1'b0, out_fire = 1'b0;
  logic prev_req = 1'b0, prev_acc = 1'b0, prev_w = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
  logic prev_cdone = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0] prev_wd = '0, prev_od = '0, e_out;
  req_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops and per-cycle protocol checks.
  always @(negedge clk) begin
    acc_fire = (ctrl_write_o || ctrl_read_o) && ctrl_ready_i;
    in_fire  = in_valid_i && in_ready_o;
    out_fire = out_valid_o && out_ready_i;
    if (nrst) begin
      if (ctrl_write_o || ctrl_read_o) begin
        req_cyc_cnt++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        check("wr_rd_exclusive", {31'd0, ctrl_write_o & ctrl_read_o}, 32'd0);
        if (prev_req && !prev_acc) begin
          check("issue_addr_stable", {29'd0, ctrl_addr_o}, {29'd0, prev_addr});
          check("issue_type_stable", {31'd0, ctrl_write_o}, {31'd0, prev_w});
          if (ctrl_write_o) check("issue_data_stable", {24'd0, ctrl_wr_data_o}, {24'd0, prev_wd});
        end
      end
      if (out_valid_o) check("no_req_in_drain", {31'd0, ctrl_write_o | ctrl_read_o}, 32'd0);
      if (acc_fire) begin
        acc_cnt++;
        if (exp_req_q.size() == 0) begin
          check("unexpected_req", {28'd0, ctrl_write_o, ctrl_addr_o}, 32'hffff);
        end else begin
          e = exp_req_q.pop_front();
          check("req_type_write", {31'd0, ctrl_write_o}, {31'd0, e.w});
          check("req_addr", {29'd0, ctrl_addr_o}, {29'd0, e.a});
          if (e.w) check("req_wr_data", {24'd0, ctrl_wr_data_o}, {24'd0, e.d});
        end
      end
      if (out_valid_o && prev_ov && !prev_or)
        check("out_data_hold", {24'd0, out_data_o}, {24'd0, prev_od});
      if (out_fire) begin
        last_out_cyc = cyc;
        if (exp_out_q.size() == 0) begin
          check("unexpected_beat", {24'd0, out_data_o}, 32'hffff);
        end else begin
          e_out = exp_out_q.pop_front();
          check("out_beat", {24'd0, out_data_o}, {24'd0, e_out});
        end
      end
      if (ctrl_done_i) last_cdone_cyc = cyc;
      if (cmd_done_o) begin
        if (prev_cdone) check("cmd_done_single_cycle", 32'd1, 32'd0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_req   = ctrl_write_o || ctrl_read_o;
    prev_acc   = acc_fire;
    prev_w     = ctrl_write_o;
    prev_addr  = ctrl_addr_o;
    prev_wd    = ctrl_wr_data_o;
    prev_ov    = out_valid_o;
    prev_or    = out_ready_i;
    prev_od    = out_data_o;
    prev_cdone = cmd_done_o;
  end

  // Controller, write-stream source and read-stream sink models.
  always begin
    @(posedge clk);
    #1;
    if (!nrst) begin
      in_q.delete();
      cd = 0;
      ctrl_done_i = 1'b0;
      ctrl_ready_i = 1'b1;
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
    end else begin
      if (in_fire && in_q.size() > 0) void'(in_q.pop_front());
      ctrl_done_i = 1'b0;
      if (acc_fire) cd = D;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ctrl_done_i = 1'b1;
          rd_data_i = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
        end
      end
      ctrl_ready_i = (cd == 0) && (stall_left == 0);
      if ((ctrl_write_o || ctrl_read_o) && stall_left > 0) stall_left--;
      in_valid_i = (in_q.size() > 0);
      in_data_i = in_valid_i ? in_q[0] : 8'h00;
      out_ready_i = 1'b1;
      if (out_valid_o && out_hold > 0) begin
        out_ready_i = 1'b0;
        out_hold--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input logic w, input int a, input logic [7:0] d);
    req_t r;
    r.w = w;
    r.a = AW'(a);
    r.d = d;
    exp_req_q.push_back(r);
  endtask

  task automatic run_cmd(input logic m, input int base, input int cnt, input int rows,
                         input logic poke_busy);
    int d0, a0;
    d0 = done_cnt;
    a0 = acc_cnt;
    step();
    first_req_cyc = -1;
    start_i = 1'b1;
    mode_i = m;
    base_addr_i = AW'(base);
    count_i = CW'(cnt);
    start_cyc = cyc;
    step();
    start_i = 1'b0;
    if (poke_busy) begin
      step();
      start_i = 1'b1;
      mode_i = ~m;
      base_addr_i = '0;
      count_i = CW'(1);
      step();
      start_i = 1'b0;
    end
    for (int i = 0; i < 400 && done_cnt == d0; i++) step();
    repeat (4) step();
    check("cmd_done_pulses", done_cnt - d0, 32'd1);
    check("accept_count", acc_cnt - a0, rows);
    check("req_queue_drained", exp_req_q.size(), 32'd0);
    check("out_queue_drained", exp_out_q.size(), 32'd0);
    check("busy_after_cmd", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int rc0, a0;
    repeat (3) step();
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_cmd_done", {31'd0, cmd_done_o}, 0);
    check("rst_in_ready", {31'd0, in_ready_o}, 0);
    check("rst_out_valid", {31'd0, out_valid_o}, 0);
    check("rst_ctrl_rw", {30'd0, ctrl_write_o, ctrl_read_o}, 0);
    check("rst_ctrl_addr", {29'd0, ctrl_addr_o}, 0);
    check("rst_ctrl_wr_data", {24'd0, ctrl_wr_data_o}, 0);
    check("rst_out_data", {24'd0, out_data_o}, 0);
    nrst = 1'b1;
    repeat (2) step();
    check("idle_busy", {31'd0, busy_o}, 0);

    // Write base=2 count=3
    in_q.push_back(8'hA1); in_q.push_back(8'hB2); in_q.push_back(8'hC3);
    push_req(1, 2, 8'hA1); push_req(1, 3, 8'hB2); push_req(1, 4, 8'hC3);
    run_cmd(1'b0, 2, 3, 3, 1'b0);
    check("write_first_req_latency", first_req_cyc - start_cyc, 2);
    check("write_done_latency", done_cyc - last_cdone_cyc, 1);

    // Wrap: base=6 count=4
    in_q.push_back(8'h11); in_q.push_back(8'h22); in_q.push_back(8'h33); in_q.push_back(8'h44);
    push_req(1, 6, 8'h11); push_req(1, 7, 8'h22); push_req(1, 0, 8'h33); push_req(1, 1, 8'h44);
    run_cmd(1'b0, 6, 4, 4, 1'b0);

    // Read base=5 count=2 with downstream stall on first beat
    rd_q.push_back(8'h3C); rd_q.push_back(8'h5A);
    push_req(0, 5, 8'h00); push_req(0, 6, 8'h00);
    exp_out_q.push_back(8'h3C); exp_out_q.push_back(8'h5A);
    out_hold = 3;
    run_cmd(1'b1, 5, 2, 2, 1'b0);
    check("read_first_req_latency", first_req_cyc - start_cyc, 1);
    check("read_done_latency", done_cyc - last_out_cyc, 1);

    // Controller backpressure: 5 cycles of ready low during issue
    in_q.push_back(8'h77);
    push_req(1, 1, 8'h77);
    stall_left = 5;
    rc0 = req_cyc_cnt;
    run_cmd(1'b0, 1, 1, 1, 1'b0);
    check("backpressure_req_cycles", req_cyc_cnt - rc0, 6);

    // Zero count
    rc0 = req_cyc_cnt;
    run_cmd(1'b0, 3, 0, 0, 1'b0);
    check("zero_count_done_latency", done_cyc - start_cyc, 1);
    check("zero_count_no_req", req_cyc_cnt - rc0, 0);

    // Count 15 saturates to 8 rows
    for (int i = 0; i < 8; i++) begin
      in_q.push_back(8'(8'h80 + i));
      push_req(1, i, 8'(8'h80 + i));
    end
    run_cmd(1'b0, 0, 15, 8, 1'b0);

    // start_i while busy is ignored
    in_q.push_back(8'hE1); in_q.push_back(8'hE2);
    push_req(1, 4, 8'hE1); push_req(1, 5, 8'hE2);
    run_cmd(1'b0, 4, 2, 2, 1'b1);

    // Reset in the middle of S_WAIT
    in_q.push_back(8'h5F); in_q.push_back(8'h6F);
    push_req(1, 3, 8'h5F); push_req(1, 4, 8'h6F);
    a0 = acc_cnt;
    step();
    start_i = 1'b1; mode_i = 1'b0; base_addr_i = 3'd3; count_i = 4'd2;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 50 && acc_cnt == a0; i++) step();
    check("rst_wait_accepted", acc_cnt - a0, 1);
    step();
    @(negedge clk);
    #1 nrst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy_o}, 0);
    check("midrst_ctrl_write", {31'd0, ctrl_write_o}, 0);
    check("midrst_ctrl_addr", {29'd0, ctrl_addr_o}, 0);
    #1 nrst = 1'b1;
    exp_req_q.delete();

    // Recovery: a plain read after reset
    rd_q.delete();
    rd_q.push_back(8'h96);
    push_req(0, 7, 8'h00);
    exp_out_q.push_back(8'h96);
    run_cmd(1'b1, 7, 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
